uart_mem_loader: RTL and testbench

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

---
 rtl/uart_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// UART-driven memory loader: programs instruction RAM, loads data RAM, runs the CPU, dumps data RAM.
// Define LOADER_CHECKSUM_EN to add a mod-256 checksum byte and an ACK/NAK reply after program upload.

module uart_mem_loader #(
   parameter int         INST_AW  = 8,
   parameter int         DATA_AW  = 16,
   parameter int         DUMP_LEN = 2**DATA_AW,
   parameter logic [7:0] ACK_BYTE = 8'd100
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               START,
   input  logic               MODE,
   input  logic               RX_DONE,
   input  logic [7:0]         RX_DATA,
   input  logic               TX_READY,
   output logic               TX_SEND,
   output logic [7:0]         TX_DATA,
   output logic               INST_EN,
   output logic               INST_WE,
   output logic [INST_AW-1:0] INST_ADDR,
   output logic [7:0]         INST_DIN,
   output logic               DATA_EN,
   output logic               DATA_WE,
   output logic [DATA_AW-1:0] DATA_ADDR,
   output logic [7:0]         DATA_DIN,
   input  logic [7:0]         DATA_DOUT,
   output logic               CPU_ENABLE,
   input  logic               CPU_FINISH,
   output logic               BUSY,
   output logic               ERR,
   output logic [4:0]         STATE
);

   typedef enum logic [4:0] {
      IDLE, P_ACK, P_ACKW, P_LEN0, P_LEN1, P_DATA, P_WR, P_CSUM, P_REPLY,
      R_REC, R_WR, R_CPU, R_WAIT, T_ADDR, T_LOAD, T_SEND, T_WAIT
   } state_t;

   localparam logic [16:0] INST_DEPTH = 17'(2**INST_AW);
   localparam logic [16:0] DATA_DEPTH = 17'(2**DATA_AW);
   localparam logic [16:0] DUMP_LAST  = 17'(DUMP_LEN - 1);

   // Reset asserts asynchronously but releases two clock edges later.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   state_t               state_q, state_d;
   logic                 tx_send_q, tx_send_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic [1:0]           tx_ph_q, tx_ph_d;
   logic                 inst_en_q, inst_en_d;
   logic                 inst_we_q, inst_we_d;
   logic [INST_AW-1:0]   inst_addr_q, inst_addr_d;
   logic [7:0]           inst_din_q, inst_din_d;
   logic                 data_en_q, data_en_d;
   logic                 data_we_q, data_we_d;
   logic [DATA_AW-1:0]   data_addr_q, data_addr_d;
   logic [7:0]           data_din_q, data_din_d;
   logic                 cpu_en_q, cpu_en_d;
   logic                 err_q, err_d;
   logic [15:0]          len_q, len_d;
   logic [16:0]          cnt_q, cnt_d;
   logic                 leave_data;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]           sum_q, sum_d;
`endif

   always_comb begin
      state_d     = state_q;
      tx_send_d   = 1'b0;
      tx_data_d   = tx_data_q;
      tx_ph_d     = tx_ph_q;
      inst_en_d   = inst_en_q;
      inst_we_d   = 1'b0;
      inst_addr_d = inst_addr_q;
      inst_din_d  = inst_din_q;
      data_en_d   = data_en_q;
      data_we_d   = 1'b0;
      data_addr_d = data_addr_q;
      data_din_d  = data_din_q;
      cpu_en_d    = cpu_en_q;
      err_d       = err_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      leave_data  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         IDLE: if (START) begin
            err_d = 1'b0;
            cnt_d = '0;
            if (!MODE) begin
               state_d   = P_ACK;
               inst_en_d = 1'b1;
               tx_data_d = ACK_BYTE;
               tx_send_d = 1'b1;
            end else begin
               state_d     = R_REC;
               data_addr_d = '0;
               data_en_d   = 1'b1;
            end
         end
         P_ACK: begin
            state_d = P_ACKW;
            tx_ph_d = 2'd1;
         end
         P_ACKW: begin
            if (tx_ph_q == 2'd1) tx_ph_d = 2'd2;
            else if (TX_READY)   state_d = P_LEN0;
         end
         P_LEN0: if (RX_DONE) begin
            len_d[7:0] = RX_DATA;
            state_d    = P_LEN1;
         end
         P_LEN1: if (RX_DONE) begin
            len_d[15:8] = RX_DATA;
            cnt_d       = '0;
            inst_addr_d = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d       = '0;
`endif
            if ({RX_DATA, len_q[7:0]} == 16'd0) leave_data = 1'b1;
            else                                 state_d    = P_DATA;
         end
         P_DATA: if (RX_DONE) begin
            inst_din_d = RX_DATA;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = sum_q + RX_DATA;
`endif
            // Bytes past the end of instruction RAM are consumed but dropped.
            if (cnt_q < INST_DEPTH) inst_we_d = 1'b1;
            else                    err_d     = 1'b1;
            state_d = P_WR;
         end
         P_WR: begin
            cnt_d = cnt_q + 17'd1;
            if (cnt_q < INST_DEPTH - 17'd1) inst_addr_d = inst_addr_q + INST_AW'(1);
            if ((cnt_q + 17'd1) == {1'b0, len_q}) leave_data = 1'b1;
            else                                  state_d    = P_DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         P_CSUM: if (RX_DONE) begin
            tx_data_d = (RX_DATA == sum_q) ? ACK_BYTE : ~ACK_BYTE;
            if (RX_DATA != sum_q) err_d = 1'b1;
            tx_send_d = 1'b1;
            tx_ph_d   = 2'd0;
            state_d   = P_REPLY;
         end
         P_REPLY: begin
            if (tx_ph_q != 2'd2) tx_ph_d = tx_ph_q + 2'd1;
            else if (TX_READY) begin
               state_d   = IDLE;
               inst_en_d = 1'b0;
            end
         end
`endif
         R_REC: begin
            if (RX_DONE) begin
               if (cnt_q < DATA_DEPTH) begin
                  data_din_d = RX_DATA;
                  data_we_d  = 1'b1;
                  state_d    = R_WR;
               end else begin
                  err_d = 1'b1;
               end
            end else if (START) begin
               state_d = R_CPU;
            end
         end
         R_WR: begin
            cnt_d   = cnt_q + 17'd1;
            if (cnt_q < DATA_DEPTH - 17'd1) data_addr_d = data_addr_q + DATA_AW'(1);
            state_d = R_REC;
         end
         R_CPU: begin
            data_en_d = 1'b0;
            cpu_en_d  = 1'b1;
            state_d   = R_WAIT;
         end
         R_WAIT: if (CPU_FINISH) begin
            cpu_en_d  = 1'b0;
            data_en_d = 1'b1;
            state_d   = T_ADDR;
         end
         T_ADDR: begin
            data_addr_d = '0;
            cnt_d       = '0;
            tx_ph_d     = 2'd0;
            state_d     = T_LOAD;
         end
         T_LOAD: begin
            // First cycle presents the address, second sees the RAM output.
            if (tx_ph_q == 2'd0) tx_ph_d = 2'd1;
            else begin
               tx_data_d = DATA_DOUT;
               tx_send_d = 1'b1;
               state_d   = T_SEND;
            end
         end
         T_SEND: begin
            state_d = T_WAIT;
            tx_ph_d = 2'd1;
         end
         T_WAIT: begin
            if (tx_ph_q == 2'd1) tx_ph_d = 2'd2;
            else if (TX_READY) begin
               if (cnt_q == DUMP_LAST) begin
                  state_d   = IDLE;
                  data_en_d = 1'b0;
               end else begin
                  cnt_d       = cnt_q + 17'd1;
                  data_addr_d = data_addr_q + DATA_AW'(1);
                  tx_ph_d     = 2'd0;
                  state_d     = T_LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (leave_data) begin
`ifdef LOADER_CHECKSUM_EN
         state_d   = P_CSUM;
`else
         state_d   = IDLE;
         inst_en_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge CLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= IDLE;
         tx_send_q   <= 1'b0;
         tx_data_q   <= '0;
         tx_ph_q     <= '0;
         inst_en_q   <= 1'b0;
         inst_we_q   <= 1'b0;
         inst_addr_q <= '0;
         inst_din_q  <= '0;
         data_en_q   <= 1'b0;
         data_we_q   <= 1'b0;
         data_addr_q <= '0;
         data_din_q  <= '0;
         cpu_en_q    <= 1'b0;
         err_q       <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         tx_send_q   <= tx_send_d;
         tx_data_q   <= tx_data_d;
         tx_ph_q     <= tx_ph_d;
         inst_en_q   <= inst_en_d;
         inst_we_q   <= inst_we_d;
         inst_addr_q <= inst_addr_d;
         inst_din_q  <= inst_din_d;
         data_en_q   <= data_en_d;
         data_we_q   <= data_we_d;
         data_addr_q <= data_addr_d;
         data_din_q  <= data_din_d;
         cpu_en_q    <= cpu_en_d;
         err_q       <= err_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign TX_SEND    = tx_send_q;
   assign TX_DATA    = tx_data_q;
   assign INST_EN    = inst_en_q;
   assign INST_WE    = inst_we_q;
   assign INST_ADDR  = inst_addr_q;
   assign INST_DIN   = inst_din_q;
   assign DATA_EN    = data_en_q;
   assign DATA_WE    = data_we_q;
   assign DATA_ADDR  = data_addr_q;
   assign DATA_DIN   = data_din_q;
   assign CPU_ENABLE = cpu_en_q;
   assign BUSY       = (state_q != IDLE);
   assign ERR        = err_q;
   assign STATE      = state_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: host/UART, RAM and CPU models around a small instance (INST_AW=2, DATA_AW=4).
module tb_uart_mem_loader;
   localparam int         IAW  = 2;
   localparam int         DAW  = 4;
   localparam int         DLEN = 4;
   localparam logic [7:0] ACK  = 8'd100;
   localparam logic [4:0] S_IDLE = 5'd0, S_P_LEN0 = 5'd3, S_R_REC = 5'd9,
                          S_R_WAIT = 5'd12, S_T_WAIT = 5'd16;

   logic           CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, MODE = 1'b0;
   logic           RX_DONE = 1'b0, TX_READY = 1'b1, CPU_FINISH = 1'b0;
   logic [7:0]     RX_DATA = 8'h00, DATA_DOUT = 8'h00;
   logic           TX_SEND, INST_EN, INST_WE, DATA_EN, DATA_WE, CPU_ENABLE, BUSY, ERR;
   logic [7:0]     TX_DATA, INST_DIN, DATA_DIN;
   logic [IAW-1:0] INST_ADDR;
   logic [DAW-1:0] DATA_ADDR;
   logic [4:0]     STATE;

   uart_mem_loader #(.INST_AW(IAW), .DATA_AW(DAW), .DUMP_LEN(DLEN), .ACK_BYTE(ACK)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .MODE(MODE), .RX_DONE(RX_DONE),
      .RX_DATA(RX_DATA), .TX_READY(TX_READY), .TX_SEND(TX_SEND), .TX_DATA(TX_DATA),
      .INST_EN(INST_EN), .INST_WE(INST_WE), .INST_ADDR(INST_ADDR), .INST_DIN(INST_DIN),
      .DATA_EN(DATA_EN), .DATA_WE(DATA_WE), .DATA_ADDR(DATA_ADDR), .DATA_DIN(DATA_DIN),
      .DATA_DOUT(DATA_DOUT), .CPU_ENABLE(CPU_ENABLE), .CPU_FINISH(CPU_FINISH),
      .BUSY(BUSY), .ERR(ERR), .STATE(STATE));

   always #5 CLK = ~CLK;

   int checks = 0, errors = 0, prot_err = 0, tx_busy = 0, hi_cnt = 0, cpu_dly = 50;
   logic [7:0]  tx_last;
   logic [7:0]  tx_q[$];
   logic [15:0] iwr_q[$], dwr_q[$];
   logic [7:0]  dmem [16];
   logic [7:0]  model_dmem [16];

   // UART transmitter: busy for a few cycles after each send strobe
   always @(posedge CLK) begin
      if (!RESET_N) begin
         tx_busy = 0;
         TX_READY <= 1'b1;
      end else if (TX_SEND) begin
         if (!TX_READY) prot_err++;
         tx_q.push_back(TX_DATA);
         tx_last = TX_DATA;
         TX_READY <= 1'b0;
         tx_busy = $urandom_range(2, 8);
      end else if (tx_busy > 0) begin
         if (TX_DATA !== tx_last) prot_err++;
         tx_busy--;
         if (tx_busy == 0) TX_READY <= 1'b1;
      end
   end

   // Port-B RAMs, read-first, one cycle read latency
   always @(posedge CLK) begin
      if (INST_EN && INST_WE) iwr_q.push_back({8'(INST_ADDR), INST_DIN});
      if (DATA_EN) begin
         if (DATA_WE) begin
            dmem[DATA_ADDR] <= DATA_DIN;
            dwr_q.push_back({8'(DATA_ADDR), DATA_DIN});
         end
         DATA_DOUT <= dmem[DATA_ADDR];
      end
   end

   // CPU: raises FINISH after cpu_dly enabled cycles
   always @(negedge CLK) begin
      if (CPU_ENABLE) begin
         hi_cnt++;
         if (hi_cnt >= cpu_dly) CPU_FINISH = 1'b1;
      end else CPU_FINISH = 1'b0;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start(input logic m);
      MODE = m; START = 1'b1;
      cyc(1);
      START = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b);
      RX_DATA = b; RX_DONE = 1'b1;
      cyc(1);
      RX_DONE = 1'b0;
      cyc(6);
   endtask

   task automatic wait_st(input logic [4:0] s, input string nm);
      int n = 0;
      while (STATE !== s && n < 3000) begin
         cyc(1);
         n++;
      end
      chk(nm, STATE, s);
   endtask

   task automatic prog(input int len, input logic [7:0] b [0:7], input logic [7:0] cs,
                       input logic eerr, input int ewr, input logic [7:0] erep, input string nm);
      int ntx;
      tx_q.delete(); iwr_q.delete();
      pulse_start(1'b0);
      wait_st(S_P_LEN0, {nm, "_len0"});
      rx(len[7:0]); rx(len[15:8]);
      for (int i = 0; i < len; i++) rx(b[i]);
`ifdef LOADER_CHECKSUM_EN
      rx(cs);
      ntx = 2;
`else
      ntx = 1;
`endif
      wait_st(S_IDLE, {nm, "_idle"});
      chk({nm, "_busy"}, BUSY, 1'b0);
      chk({nm, "_err"}, ERR, eerr);
      chk({nm, "_nwr"}, iwr_q.size(), ewr);
      for (int i = 0; i < ewr && i < iwr_q.size(); i++)
         chk({nm, "_wr"}, iwr_q[i], {8'(i), b[i]});
      chk({nm, "_ntx"}, tx_q.size(), ntx);
      if (tx_q.size() > 0) chk({nm, "_ack"}, tx_q[0], ACK);
      if (ntx == 2 && tx_q.size() > 1) chk({nm, "_reply"}, tx_q[1], erep);
      if (ntx == 1) chk({nm, "_inst_en"}, INST_EN, 1'b0);
   endtask

   task automatic run(input int n, input logic [7:0] b [0:23], input int dly, input string nm);
      int nwr;
      tx_q.delete(); dwr_q.delete();
      hi_cnt = 0; cpu_dly = dly;
      nwr = (n > 16) ? 16 : n;
      pulse_start(1'b1);
      for (int i = 0; i < n; i++) begin
         rx(b[i]);
         if (i < 16) model_dmem[i] = b[i];
      end
      if (n > 16) begin
         chk({nm, "_addr_hold"}, DATA_ADDR, 4'd15);
         chk({nm, "_err_ovf"}, ERR, 1'b1);
         chk({nm, "_still_rec"}, STATE, S_R_REC);
      end
      pulse_start(1'b1);
      wait_st(S_IDLE, {nm, "_idle"});
      chk({nm, "_err"}, ERR, n > 16);
      chk({nm, "_cpu_cycles"}, hi_cnt, dly);
      chk({nm, "_nwr"}, dwr_q.size(), nwr);
      for (int i = 0; i < nwr && i < dwr_q.size(); i++)
         chk({nm, "_wr"}, dwr_q[i], {8'(i), b[i]});
      chk({nm, "_ntx"}, tx_q.size(), DLEN);
      for (int k = 0; k < DLEN && k < tx_q.size(); k++)
         chk({nm, "_dump"}, tx_q[k], model_dmem[k]);
      chk({nm, "_data_en"}, DATA_EN, 1'b0);
   endtask

   typedef struct {
      int         len;
      logic [7:0] b [0:7];
      logic [7:0] cs;
      logic       err_plain;
      logic       err_cs;
      int         wr;
      logic [7:0] reply;
   } pvec_t;

   initial begin
      pvec_t      tbl [6];
      logic [7:0] pb [0:7];
      logic [7:0] rb [0:23];
      logic [7:0] sum, cs;
      logic       bad, eerr;
      int         len, n;

      for (int i = 0; i < 16; i++) begin dmem[i] = 8'h00; model_dmem[i] = 8'h00; end
      tbl[0] = '{3, '{8'h11, 8'h22, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 8'h66, 1'b0, 1'b0, 3, ACK};
      tbl[1] = '{2, '{8'h01, 8'h02, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 8'h03, 1'b0, 1'b0, 2, ACK};
      tbl[2] = '{2, '{8'h01, 8'h02, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 8'h04, 1'b0, 1'b1, 2, 8'h9B};
      tbl[3] = '{6, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0, 8'h0}, 8'h15, 1'b1, 1'b1, 4, ACK};
      tbl[4] = '{0, '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 8'h00, 1'b0, 1'b0, 0, ACK};
      tbl[5] = '{4, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0, 8'h0, 8'h0, 8'h0}, 8'hFC, 1'b0, 1'b0, 4, ACK};

      // reset state
      cyc(3);
      chk("rst_state", STATE, S_IDLE);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_outs", {TX_SEND, INST_EN, INST_WE, DATA_EN, DATA_WE, CPU_ENABLE, ERR}, 7'd0);
      chk("rst_tx_data", TX_DATA, 8'h00);
      chk("rst_addrs", {INST_ADDR, DATA_ADDR}, 6'd0);

      // START on the first two edges after release must be ignored
      RESET_N = 1'b1; MODE = 1'b0; START = 1'b1;
      cyc(2);
      START = 1'b0;
      cyc(2);
      chk("rst_release_sync", STATE, S_IDLE);
      chk("rst_release_tx", tx_q.size(), 0);

      for (int t = 0; t < 6; t++) begin
`ifdef LOADER_CHECKSUM_EN
         eerr = tbl[t].err_cs;
`else
         eerr = tbl[t].err_plain;
`endif
         prog(tbl[t].len, tbl[t].b, tbl[t].cs, eerr, tbl[t].wr, tbl[t].reply, $sformatf("prog%0d", t));
      end

      for (int r = 0; r < 3; r++) begin
         len = $urandom_range(0, 6);
         sum = 8'h00;
         for (int i = 0; i < 8; i++) begin
            pb[i] = 8'($urandom);
            if (i < len) sum = sum + pb[i];
         end
         bad = 1'($urandom_range(0, 1));
         cs  = bad ? sum + 8'd1 : sum;
`ifdef LOADER_CHECKSUM_EN
         eerr = (len > 4) || bad;
`else
         eerr = (len > 4);
`endif
         prog(len, pb, cs, eerr, (len > 4) ? 4 : len, bad ? ~ACK : ACK, $sformatf("rprog%0d", r));
      end

      for (int i = 0; i < 24; i++) rb[i] = 8'h00;
      rb[0] = 8'hAA; rb[1] = 8'hBB;
      run(2, rb, 50, "run_aabb");

      // RX_DONE together with START in R_REC: byte stored, stay receiving
      tx_q.delete(); dwr_q.delete(); hi_cnt = 0; cpu_dly = 5;
      pulse_start(1'b1);
      RX_DATA = 8'h5C; RX_DONE = 1'b1; START = 1'b1;
      cyc(1);
      RX_DONE = 1'b0; START = 1'b0;
      cyc(1);
      chk("coinc_state", STATE, S_R_REC);
      model_dmem[0] = 8'h5C;
      cyc(4);
      rx(8'h7E); model_dmem[1] = 8'h7E;
      pulse_start(1'b1);
      wait_st(S_IDLE, "coinc_idle");
      chk("coinc_nwr", dwr_q.size(), 2);
      if (dwr_q.size() > 0) chk("coinc_wr0", dwr_q[0], 16'h005C);
      chk("coinc_ntx", tx_q.size(), DLEN);
      for (int k = 0; k < DLEN && k < tx_q.size(); k++) chk("coinc_dump", tx_q[k], model_dmem[k]);

      for (int r = 0; r < 3; r++) begin
         n = (r == 0) ? 19 : $urandom_range(0, 20);
         for (int i = 0; i < 24; i++) rb[i] = 8'($urandom);
         run(n, rb, $urandom_range(1, 20), $sformatf("rrun%0d", r));
      end

      // async reset during CPU run
      hi_cnt = 0; cpu_dly = 1000;
      pulse_start(1'b1);
      rx(8'h31); model_dmem[0] = 8'h31;
      pulse_start(1'b1);
      wait_st(S_R_WAIT, "rwait_reach");
      chk("rwait_cpu_on", CPU_ENABLE, 1'b1);
      #2 RESET_N = 1'b0;
      #1;
      chk("rwait_rst_outs", {CPU_ENABLE, TX_SEND, DATA_EN, BUSY}, 4'd0);
      chk("rwait_rst_state", STATE, S_IDLE);
      cyc(2);
      RESET_N = 1'b1;
      cyc(3);

      // async reset while waiting on the transmitter during the dump
      hi_cnt = 0; cpu_dly = 3;
      pulse_start(1'b1);
      rx(8'h41); model_dmem[0] = 8'h41;
      pulse_start(1'b1);
      wait_st(S_T_WAIT, "twait_reach");
      #2 RESET_N = 1'b0;
      #1;
      chk("twait_rst_outs", {CPU_ENABLE, TX_SEND, DATA_EN, ERR}, 4'd0);
      chk("twait_rst_tx_data", TX_DATA, 8'h00);
      chk("twait_rst_state", STATE, S_IDLE);
      cyc(2);
      RESET_N = 1'b1;
      cyc(3);

      run(1, rb, 7, "post_rst_run");
      chk("tx_protocol", prot_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
